// File: rtl/asteroid_spawn_if.sv
// asteroid_spawn_if: spawn handshake, slot release and status bundle of the scheduler.
// Signal suffixes are from the scheduler's point of view.
interface asteroid_spawn_if #(
    parameter int NUM_SLOTS = 10
);
    logic                 enable_i;
    logic [NUM_SLOTS-1:0] release_i;
    logic                 spawn_ready_i;
    logic                 spawn_valid_o;
    logic [3:0]           spawn_slot_o;
    logic [9:0]           spawn_x_o;
    logic [NUM_SLOTS-1:0] slot_active_o;
    logic                 full_o;
    logic [7:0]           spawn_count_o;

    modport slave (
        input  enable_i, release_i, spawn_ready_i,
        output spawn_valid_o, spawn_slot_o, spawn_x_o, slot_active_o, full_o, spawn_count_o
    );

    modport master (
        output enable_i, release_i, spawn_ready_i,
        input  spawn_valid_o, spawn_slot_o, spawn_x_o, slot_active_o, full_o, spawn_count_o
    );
endinterface

// File: rtl/asteroid_spawn_scheduler.sv
// asteroid_spawn_scheduler: paces obstacle spawns, allocates free sprite slots round-robin
// and offers each spawn with an LFSR-derived start x over a valid/ready handshake.
module asteroid_spawn_scheduler #(
    parameter int NUM_SLOTS      = 10,
    parameter int SPAWN_INTERVAL = 4,
    parameter int X_LIMIT        = 600
) (
    input logic               slowclk,
    input logic               reset_n,
    asteroid_spawn_if.slave   bus
);
    localparam int SW = $clog2(NUM_SLOTS);

    typedef enum logic [1:0] {IDLE, WAIT, ALLOC, OFFER} state_t;

    state_t               state_q, state_d;
    logic [7:0]           cnt_q, cnt_d, count_q, count_d;
    logic [3:0]           ptr_q, ptr_d, slot_q, slot_d, pick;
    logic [9:0]           lfsr_q, x_q, x_d;
    logic [NUM_SLOTS-1:0] active_q, set_mask;
    logic                 found, hs;

    function automatic int wrap(input int v);
        return v >= NUM_SLOTS ? v - NUM_SLOTS : v;
    endfunction

    assign hs       = state_q == OFFER && bus.spawn_ready_i;
    assign set_mask = hs ? NUM_SLOTS'(1) << slot_q : '0;

    // Scan downward so the last hit is the first free slot at or after ptr.
    always_comb begin
        found = 1'b0;
        pick  = ptr_q;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!active_q[SW'(wrap(int'(ptr_q) + i))]) begin
                found = 1'b1;
                pick  = 4'(wrap(int'(ptr_q) + i));
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        slot_d  = slot_q;
        x_d     = x_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                cnt_d   = '0;
                state_d = bus.enable_i ? WAIT : IDLE;
            end
            WAIT: begin
                cnt_d   = (!bus.enable_i || cnt_q == 8'(SPAWN_INTERVAL - 1)) ? '0 : cnt_q + 8'd1;
                state_d = !bus.enable_i ? IDLE : cnt_q == 8'(SPAWN_INTERVAL - 1) ? ALLOC : WAIT;
            end
            ALLOC: begin
                cnt_d   = '0;
                state_d = !bus.enable_i ? IDLE : found ? OFFER : WAIT;
                if (bus.enable_i && found) begin
                    slot_d = pick;
                    x_d    = int'(lfsr_q) < X_LIMIT ? lfsr_q : lfsr_q - 10'd512;
                end
            end
            OFFER: begin
                if (hs) begin
                    cnt_d   = '0;
                    ptr_d   = slot_q == 4'(NUM_SLOTS - 1) ? 4'd0 : slot_q + 4'd1;
                    count_d = count_q == 8'hFF ? count_q : count_q + 8'd1;
                    state_d = bus.enable_i ? WAIT : IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge slowclk) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            ptr_q    <= '0;
            slot_q   <= '0;
            x_q      <= '0;
            count_q  <= '0;
            lfsr_q   <= 10'h001;
            active_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ptr_q    <= ptr_d;
            slot_q   <= slot_d;
            x_q      <= x_d;
            count_q  <= count_d;
            lfsr_q   <= {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};
            active_q <= (active_q & ~bus.release_i) | set_mask;
        end
    end

    assign bus.spawn_valid_o = state_q == OFFER;
    assign bus.spawn_slot_o  = slot_q;
    assign bus.spawn_x_o     = x_q;
    assign bus.slot_active_o = active_q;
    assign bus.full_o        = &active_q;
    assign bus.spawn_count_o = count_q;
endmodule

// File: tb/tb_asteroid_spawn_scheduler.sv
// tb_asteroid_spawn_scheduler: directed vectors and hand-written sequences for the
// spawn scheduler with default parameters (10 slots, interval 4, x limit 600).
module tb_asteroid_spawn_scheduler;
    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    asteroid_spawn_if #(.NUM_SLOTS(10)) bus ();

    asteroid_spawn_scheduler dut (
        .slowclk (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] rel;
        int         exp_slot;
        logic [9:0] exp_active;
        logic       exp_full;
        logic [7:0] exp_cnt;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n           = 1'b0;
        bus.enable_i      = 1'b0;
        bus.release_i     = '0;
        bus.spawn_ready_i = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic wait_offer(input string name);
        int n = 0;
        while (!bus.spawn_valid_o && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(bus.spawn_valid_o), 1);
    endtask

    task automatic handshake();
        bus.spawn_ready_i = 1'b1;
        @(negedge clk);
        bus.spawn_ready_i = 1'b0;
    endtask

    task automatic release_pulse(input logic [9:0] m);
        bus.release_i = m;
        @(negedge clk);
        bus.release_i = '0;
    endtask

    initial begin
        logic       seen, stable;
        logic [3:0] s0;
        logic [9:0] x0;

        for (int i = 0; i < 10; i++)
            tbl[i] = '{10'h000, i, 10'((1 << (i + 1)) - 1), i == 9, 8'(i + 1)};
        tbl[10] = '{10'h008, 3, 10'h3FF, 1'b1, 8'd11};

        do_reset();
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            seen |= bus.spawn_valid_o | (|bus.slot_active_o) | (|bus.spawn_count_o)
                  | (|bus.spawn_x_o) | (|bus.spawn_slot_o) | bus.full_o;
        end
        chk("idle_any_output", 32'(seen), 0);
        chk("rst_valid", 32'(bus.spawn_valid_o), 0);
        chk("rst_active", 32'(bus.slot_active_o), 0);
        chk("rst_full", 32'(bus.full_o), 0);
        chk("rst_count", 32'(bus.spawn_count_o), 0);

        do_reset();
        bus.enable_i = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            chk($sformatf("first_valid_edge%0d", k), 32'(bus.spawn_valid_o), 32'(k == 6));
        end
        chk("first_slot", 32'(bus.spawn_slot_o), 0);
        chk("first_x", 32'(bus.spawn_x_o), 32'h020);
        handshake();
        chk("first_active", 32'(bus.slot_active_o), 32'h001);
        chk("first_count", 32'(bus.spawn_count_o), 1);

        do_reset();
        bus.enable_i = 1'b1;
        wait_offer("hold_offer");
        s0 = bus.spawn_slot_o;
        x0 = bus.spawn_x_o;
        stable = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (k == 5) bus.enable_i = 1'b0;
            @(negedge clk);
            stable &= bus.spawn_valid_o && bus.spawn_slot_o == s0 && bus.spawn_x_o == x0;
        end
        chk("hold_stable", 32'(stable), 1);
        handshake();
        chk("hold_active", 32'(bus.slot_active_o), 32'h001);
        chk("hold_count", 32'(bus.spawn_count_o), 1);
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            seen |= bus.spawn_valid_o;
        end
        chk("hold_idle_after", 32'(seen), 0);

        do_reset();
        bus.enable_i = 1'b1;
        for (int i = 0; i < 11; i++) begin
            if (tbl[i].rel != '0) begin
                seen = 1'b0;
                repeat (20) begin
                    @(negedge clk);
                    seen |= bus.spawn_valid_o;
                end
                chk("full_no_offer", 32'(seen), 0);
                release_pulse(tbl[i].rel);
                chk("release_active", 32'(bus.slot_active_o), 32'(tbl[i].exp_active & ~tbl[i].rel));
                chk("release_full", 32'(bus.full_o), 0);
            end
            wait_offer($sformatf("tbl%0d_offer", i));
            chk($sformatf("tbl%0d_slot", i), 32'(bus.spawn_slot_o), 32'(tbl[i].exp_slot));
            chk($sformatf("tbl%0d_x_range", i), 32'(bus.spawn_x_o < 10'd600), 1);
            handshake();
            chk($sformatf("tbl%0d_active", i), 32'(bus.slot_active_o), 32'(tbl[i].exp_active));
            chk($sformatf("tbl%0d_full", i), 32'(bus.full_o), 32'(tbl[i].exp_full));
            chk($sformatf("tbl%0d_count", i), 32'(bus.spawn_count_o), 32'(tbl[i].exp_cnt));
        end

        do_reset();
        bus.enable_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            wait_offer("rr_offer");
            chk("rr_slot", 32'(bus.spawn_slot_o), 32'(i));
            handshake();
        end
        release_pulse(10'h001);
        wait_offer("rr_offer2");
        chk("rr_skip_slot0", 32'(bus.spawn_slot_o), 2);
        handshake();
        for (int i = 3; i < 5; i++) begin
            wait_offer("rr_offer");
            handshake();
        end
        wait_offer("set_wins_offer");
        chk("set_wins_slot", 32'(bus.spawn_slot_o), 5);
        bus.release_i = 10'h020;
        handshake();
        bus.release_i = '0;
        chk("set_wins_active", 32'(bus.slot_active_o), 32'h03E);

        do_reset();
        bus.enable_i = 1'b1;
        for (int i = 0; i < 256; i++) begin
            wait_offer("sat_offer");
            s0 = bus.spawn_slot_o;
            handshake();
            if (i == 253) chk("sat_count_254", 32'(bus.spawn_count_o), 254);
            if (i == 254) chk("sat_count_255", 32'(bus.spawn_count_o), 255);
            release_pulse(10'(1 << s0));
        end
        chk("sat_count_hold", 32'(bus.spawn_count_o), 255);

        wait_offer("rst_offer");
        @(negedge clk);
        reset_n = 1'b0;
        bus.spawn_ready_i = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        bus.spawn_ready_i = 1'b0;
        chk("offer_rst_valid", 32'(bus.spawn_valid_o), 0);
        chk("offer_rst_active", 32'(bus.slot_active_o), 0);
        chk("offer_rst_count", 32'(bus.spawn_count_o), 0);
        chk("offer_rst_slot", 32'(bus.spawn_slot_o), 0);
        chk("offer_rst_x", 32'(bus.spawn_x_o), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
